// File: rtl/core_pkg.sv
// Shared core types: register-file geometry, writeback arbiter FSM states and
// the writeback request record.
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic {
    ARB_RUN   = 1'b0,
    ARB_STALL = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// Aux-result queue for the writeback arbiter. Each slot carries an occupied bit
// and a live bit; a younger pipe write to the same rd clears live in place.
module wb_aux_fifo
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_rd,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_kill_en,
  input  logic [ADDR_W-1:0] i_kill_rd,
  output logic              o_head_occ,
  output logic              o_head_live,
  output logic [ADDR_W-1:0] o_head_rd,
  output logic [DATA_W-1:0] o_head_data,
  output logic [AW:0]       o_count,
  output logic [31:0]       o_pending_mask
);

  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  logic [DEPTH-1:0]             w_occ, w_live;
  logic [DEPTH-1:0][ADDR_W-1:0] w_ent_rd;
  logic [DEPTH-1:0][DATA_W-1:0] w_ent_data;
  logic [31:0]                  w_pending;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic              r_occ, r_live;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic              w_wr, w_rd, w_kill;

    assign w_wr   = i_push && (r_wptr == AW'(i));
    assign w_rd   = i_pop && (r_rptr == AW'(i));
    assign w_kill = i_kill_en && r_occ && (r_rd == i_kill_rd);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_occ  <= 1'b0;
        r_live <= 1'b0;
        r_rd   <= '0;
        r_data <= '0;
      end else if (w_wr) begin
        r_occ  <= 1'b1;
        r_live <= 1'b1;
        r_rd   <= i_push_rd;
        r_data <= i_push_data;
      end else if (w_rd) begin
        r_occ  <= 1'b0;
        r_live <= 1'b0;
      end else if (w_kill) begin
        r_live <= 1'b0;
      end
    end

    assign w_occ[i]      = r_occ;
    assign w_live[i]     = r_live;
    assign w_ent_rd[i]   = r_rd;
    assign w_ent_data[i] = r_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // rd=0 is never enqueued, but bit 0 is forced low regardless.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_occ[i] && w_live[i]) w_pending[w_ent_rd[i]] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign o_head_occ     = w_occ[r_rptr];
  assign o_head_live    = w_live[r_rptr];
  assign o_head_rd      = w_ent_rd[r_rptr];
  assign o_head_data    = w_ent_data[r_rptr];
  assign o_count        = r_count;
  assign o_pending_mask = w_pending;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, aux results
// queue in a FIFO, and a starvation FSM requests a stall to drain the head.
module wb_port_arbiter
  import core_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_wb_valid,
  input  logic [ADDR_W-1:0] pipe_wb_rd,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic              aux_valid,
  input  logic [ADDR_W-1:0] aux_rd,
  input  logic [DATA_W-1:0] aux_data,
  output logic              aux_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_stall_req,
  output logic [31:0]       pending_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] LIM_M1   = SW'(STARVE_LIMIT - 1);

  logic              w_head_occ, w_head_live;
  logic [ADDR_W-1:0] w_head_rd;
  logic [DATA_W-1:0] w_head_data;
  logic [AW:0]       w_count;
  logic [31:0]       w_pending;
  logic              w_pipe_sel, w_pop, w_aux_we, w_push, w_aux_ready;

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  arb_state_t        r_state;
  logic [SW-1:0]     r_starve;
  logic              r_stall;

  // A killed head never competes with the pipe; it is retired immediately.
  assign w_pipe_sel  = pipe_wb_valid && (pipe_wb_rd != '0);
  assign w_pop       = w_head_occ && (!w_head_live || !w_pipe_sel);
  assign w_aux_we    = w_pop && w_head_live;
  assign w_aux_ready = (w_count < FULL_CNT) && !reset;
  assign w_push      = aux_valid && w_aux_ready && (aux_rd != '0);

  wb_aux_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .i_push         (w_push),
    .i_push_rd      (aux_rd),
    .i_push_data    (aux_data),
    .i_pop          (w_pop),
    .i_kill_en      (w_pipe_sel),
    .i_kill_rd      (pipe_wb_rd),
    .o_head_occ     (w_head_occ),
    .o_head_live    (w_head_live),
    .o_head_rd      (w_head_rd),
    .o_head_data    (w_head_data),
    .o_count        (w_count),
    .o_pending_mask (w_pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_pipe_sel || w_aux_we;
      if (w_pipe_sel) begin
        r_waddr <= pipe_wb_rd;
        r_wdata <= pipe_wb_data;
      end else if (w_aux_we) begin
        r_waddr <= w_head_rd;
        r_wdata <= w_head_data;
      end
    end
  end

  // In RUN, an occupied head that is not popped has lost to the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ARB_RUN;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      case (r_state)
        ARB_RUN: begin
          if (!w_head_occ || w_pop) begin
            r_starve <= '0;
          end else if (r_starve == LIM_M1) begin
            r_state <= ARB_STALL;
            r_stall <= 1'b1;
          end else begin
            r_starve <= r_starve + 1'b1;
          end
        end
        ARB_STALL: begin
          if (w_pop || !w_head_occ) begin
            r_state  <= ARB_RUN;
            r_starve <= '0;
            r_stall  <= 1'b0;
          end
        end
        default: begin
          r_state  <= ARB_RUN;
          r_starve <= '0;
          r_stall  <= 1'b0;
        end
      endcase
    end
  end

  assign aux_ready    = w_aux_ready;
  assign rf_we        = r_we;
  assign rf_waddr     = r_waddr;
  assign rf_wdata     = r_wdata;
  assign wb_stall_req = r_stall;
  assign pending_mask = w_pending;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: required register-file writes are
// queued as stimulus is driven and matched against rf_* by a monitor.
module tb_wb_port_arbiter;
  import core_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              pipe_wb_valid;
  logic [ADDR_W-1:0] pipe_wb_rd;
  logic [DATA_W-1:0] pipe_wb_data;
  logic              aux_valid;
  logic [ADDR_W-1:0] aux_rd;
  logic [DATA_W-1:0] aux_data;
  logic              aux_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_stall_req;
  logic [31:0]       pending_mask;

  int      n_vec = 0;
  int      n_err = 0;
  bit      mon_en = 1'b0;
  wb_req_t exp_q[$];

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .aux_valid(aux_valid), .aux_rd(aux_rd), .aux_data(aux_data), .aux_ready(aux_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_stall_req(wb_stall_req), .pending_mask(pending_mask)
  );

  always @(posedge clk) begin
    wb_req_t e;
    #1;
    if (mon_en && !reset && rf_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rf_write: got unexpected rd=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
          n_err++;
          $display("FAIL rf_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_waddr, rf_wdata, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    pipe_wb_valid = v; pipe_wb_rd = rd; pipe_wb_data = d;
  endtask

  task automatic set_aux(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    aux_valid = v; aux_rd = rd; aux_data = d;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    exp_q.push_back('{valid: 1'b1, rd: rd, data: d});
  endtask

  task automatic check_drained(input string name);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_pipe(0, 0, 0);
    set_aux(0, 0, 0);
    #2;
    n_vec++;
    if ({rf_we, rf_waddr, rf_wdata, wb_stall_req, pending_mask, aux_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h stall=%b mask=%h ready=%b, required all 0",
               rf_we, rf_waddr, rf_wdata, wb_stall_req, pending_mask, aux_ready);
    end
    step(); step();
    reset = 1'b0;
    mon_en = 1'b1;
    step();
    n_vec++;
    if (aux_ready !== 1'b1 || rf_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got ready=%b we=%b, required ready=1 we=0", aux_ready, rf_we);
    end
  endtask

  task automatic test_contention();
    n_vec++;
    if (aux_ready !== 1'b1) begin
      n_err++; $display("FAIL cont_ready: got %b, required 1", aux_ready);
    end
    set_pipe(1, 5, 32'hAAAA_0001);
    set_aux(1, 7, 32'h0000_1234);
    expect_wr(5, 32'hAAAA_0001);
    step();
    set_pipe(1, 6, 32'hAAAA_0002);
    set_aux(0, 0, 0);
    expect_wr(6, 32'hAAAA_0002);
    n_vec++;
    if (pending_mask !== 32'h0000_0080) begin
      n_err++; $display("FAIL cont_mask_push: got %h, required %h", pending_mask, 32'h80);
    end
    step();
    set_pipe(0, 0, 0);
    expect_wr(7, 32'h0000_1234);
    n_vec++;
    if (pending_mask !== 32'h0000_0080) begin
      n_err++; $display("FAIL cont_mask_wait: got %h, required %h", pending_mask, 32'h80);
    end
    step();
    n_vec++;
    if (pending_mask !== 32'h0) begin
      n_err++; $display("FAIL cont_mask_pop: got %h, required 0", pending_mask);
    end
    step();
    n_vec++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL cont_idle_we: got %b, required 0", rf_we);
    end
    check_drained("contention");
  endtask

  task automatic test_waw();
    set_aux(1, 9, 32'h0000_DEAD);
    step();
    set_aux(0, 0, 0);
    set_pipe(1, 9, 32'h0000_BEEF);
    expect_wr(9, 32'h0000_BEEF);
    n_vec++;
    if (pending_mask !== 32'h0000_0200) begin
      n_err++; $display("FAIL waw_mask_set: got %h, required %h", pending_mask, 32'h200);
    end
    step();
    set_pipe(0, 0, 0);
    n_vec++;
    if (pending_mask !== 32'h0) begin
      n_err++; $display("FAIL waw_mask_clr: got %h, required 0", pending_mask);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (rf_we !== 1'b0) begin
        n_err++; $display("FAIL waw_no_second_write: got we=%b rd=%0d, required we=0", rf_we, rf_waddr);
      end
    end
    n_vec++;
    if (aux_ready !== 1'b1) begin
      n_err++; $display("FAIL waw_fifo_empty: got ready=%b, required 1", aux_ready);
    end
    check_drained("waw");
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 6; k++) begin
      set_pipe(1, ADDR_W'(10 + k), 32'hC000_0000 + k);
      expect_wr(ADDR_W'(10 + k), 32'hC000_0000 + k);
      if (k == 0) set_aux(1, 3, 32'h0000_3333);
      else        set_aux(0, 0, 0);
      step();
      n_vec++;
      if (wb_stall_req !== (k >= 4)) begin
        n_err++;
        $display("FAIL starve_stall_k%0d: got %b, required %b", k, wb_stall_req, (k >= 4));
      end
    end
    n_vec++;
    if (pending_mask !== 32'h0000_0008) begin
      n_err++; $display("FAIL starve_mask: got %h, required %h", pending_mask, 32'h8);
    end
    set_pipe(0, 0, 0);
    expect_wr(3, 32'h0000_3333);
    step();
    n_vec++;
    if (wb_stall_req !== 1'b0 || rf_we !== 1'b1) begin
      n_err++; $display("FAIL starve_release: got stall=%b we=%b, required stall=0 we=1", wb_stall_req, rf_we);
    end
    check_drained("starvation");
  endtask

  task automatic test_full_x0();
    set_pipe(1, 12, 32'h0000_0C12);
    set_aux(1, 20, 32'h0000_0020);
    expect_wr(12, 32'h0000_0C12);
    step();
    set_pipe(1, 13, 32'h0000_0C13);
    set_aux(1, 21, 32'h0000_0021);
    expect_wr(13, 32'h0000_0C13);
    n_vec++;
    if (aux_ready !== 1'b1) begin
      n_err++; $display("FAIL full_ready_one: got %b, required 1", aux_ready);
    end
    step();
    set_pipe(1, 14, 32'h0000_0C14);
    set_aux(1, 22, 32'h0000_0022);
    expect_wr(14, 32'h0000_0C14);
    n_vec++;
    if (aux_ready !== 1'b0 || pending_mask !== 32'h0030_0000) begin
      n_err++; $display("FAIL full_state: got ready=%b mask=%h, required ready=0 mask=%h",
                        aux_ready, pending_mask, 32'h0030_0000);
    end
    step();
    set_pipe(0, 0, 0);
    expect_wr(20, 32'h0000_0020);
    n_vec++;
    if (aux_ready !== 1'b0) begin
      n_err++; $display("FAIL full_hold: got ready=%b, required 0", aux_ready);
    end
    step();
    expect_wr(21, 32'h0000_0021);
    n_vec++;
    if (aux_ready !== 1'b1) begin
      n_err++; $display("FAIL full_after_pop: got ready=%b, required 1", aux_ready);
    end
    step();
    set_aux(0, 0, 0);
    expect_wr(22, 32'h0000_0022);
    n_vec++;
    if (pending_mask !== 32'h0040_0000) begin
      n_err++; $display("FAIL full_held_entry: got %h, required %h", pending_mask, 32'h0040_0000);
    end
    step();
    check_drained("full");

    set_aux(1, 0, 32'h0000_0BAD);
    n_vec++;
    if (aux_ready !== 1'b1) begin
      n_err++; $display("FAIL x0_aux_ready: got %b, required 1", aux_ready);
    end
    step();
    set_aux(0, 0, 0);
    n_vec++;
    if (pending_mask !== 32'h0 || aux_ready !== 1'b1) begin
      n_err++; $display("FAIL x0_aux_drop: got mask=%h ready=%b, required mask=0 ready=1", pending_mask, aux_ready);
    end
    step();
    n_vec++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL x0_aux_no_we: got %b, required 0", rf_we);
    end

    set_aux(1, 15, 32'h0000_0015);
    set_pipe(1, 0, 32'h0BAD_0000);
    step();
    set_aux(0, 0, 0);
    n_vec++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL x0_pipe_no_we: got %b, required 0", rf_we);
    end
    expect_wr(15, 32'h0000_0015);
    step();
    set_pipe(0, 0, 0);
    n_vec++;
    if (rf_we !== 1'b1 || pending_mask !== 32'h0) begin
      n_err++; $display("FAIL x0_pipe_head_pop: got we=%b mask=%h, required we=1 mask=0", rf_we, pending_mask);
    end
    check_drained("x0");
  endtask

  task automatic test_reset_midop();
    for (int k = 0; k < 6; k++) begin
      set_pipe(1, ADDR_W'(10 + k), 32'hD000_0000 + k);
      expect_wr(ADDR_W'(10 + k), 32'hD000_0000 + k);
      if (k < 2) set_aux(1, ADDR_W'(25 + k), 32'h0000_0025 + k);
      else       set_aux(0, 0, 0);
      step();
    end
    set_pipe(0, 0, 0);
    n_vec++;
    if (wb_stall_req !== 1'b1 || aux_ready !== 1'b0 || pending_mask !== 32'h0600_0000) begin
      n_err++; $display("FAIL midop_state: got stall=%b ready=%b mask=%h, required stall=1 ready=0 mask=%h",
                        wb_stall_req, aux_ready, pending_mask, 32'h0600_0000);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL midop_writes: got %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({rf_we, rf_waddr, rf_wdata, wb_stall_req, pending_mask, aux_ready} !== '0) begin
      n_err++;
      $display("FAIL midop_async_reset: got we=%b addr=%0d data=%h stall=%b mask=%h ready=%b, required all 0",
               rf_we, rf_waddr, rf_wdata, wb_stall_req, pending_mask, aux_ready);
    end
    step();
    reset = 1'b0;
    step();
    n_vec++;
    if (aux_ready !== 1'b1 || rf_we !== 1'b0 || wb_stall_req !== 1'b0 || pending_mask !== 32'h0) begin
      n_err++; $display("FAIL midop_release: got ready=%b we=%b stall=%b mask=%h, required ready=1 others 0",
                        aux_ready, rf_we, wb_stall_req, pending_mask);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_waw();
    test_starvation();
    test_full_x0();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
